// File: rtl/ysyx_23060075_ifu_prefetch_if.sv
// ---------------------------------------------------------------------------
// ysyx_23060075_ifu_prefetch_if
// Bundles the instruction prefetcher's three channels:
//   redirect : redirect_valid / redirect_pc       (core -> prefetcher)
//   mem req  : mem_req_valid / mem_req_ready / mem_req_addr
//   mem rsp  : mem_rsp_valid / mem_rsp_data / mem_rsp_err (no ready: the
//              memory returns exactly one response per accepted request,
//              never in the cycle of acceptance)
//   out      : out_valid / out_ready / out_inst / out_pc / out_err
// Handshake rule for every valid/ready pair: a transfer happens on a rising
// clk edge where valid && ready are both 1; once valid is raised the sender
// keeps valid and its payload stable until that transfer, and ready may
// depend combinationally on nothing the receiver did not already see.
// Modports: master = prefetcher side, slave = core/memory environment side.
// ---------------------------------------------------------------------------
interface ysyx_23060075_ifu_prefetch_if #(
    parameter int XLEN = 32
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_req_addr;

    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_data;
    logic            mem_rsp_err;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_inst;
    logic [XLEN-1:0] out_pc;
    logic            out_err;

    modport master (
        input  redirect_valid, redirect_pc,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
        input  out_ready,
        output mem_req_valid, mem_req_addr,
        output out_valid, out_inst, out_pc, out_err
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
        output out_ready,
        input  mem_req_valid, mem_req_addr,
        input  out_valid, out_inst, out_pc, out_err
    );
endinterface

// File: rtl/ysyx_23060075_ifu_prefetch.sv
// ---------------------------------------------------------------------------
// ysyx_23060075_ifu_prefetch
// Sequential instruction prefetcher: issues word-aligned fetches (one
// outstanding at a time) and queues {pc, inst, err} in a DEPTH-entry FIFO
// for decode. A redirect flushes the FIFO and restarts fetch; a request that
// is already on the bus when a redirect arrives has its response dropped.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   bus         : ysyx_23060075_ifu_prefetch_if.master (redirect, mem, out)
//   dbg_state   : current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 DROP)
// Optional feature macro: YSYX_23060075_IFU_PREFETCH_BYPASS_EN -- when the
// FIFO is empty a response in WAIT is forwarded to out_* in the same cycle
// and is not queued if decode takes it.
// ---------------------------------------------------------------------------
module ysyx_23060075_ifu_prefetch #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                               clk,
    input  logic                               rst,
    ysyx_23060075_ifu_prefetch_if.master       bus,
    output logic [1:0]                         dbg_state
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t          state, state_next;
    logic [XLEN-1:0] fpc;          // next address to be fetched
    logic [XLEN-1:0] req_addr;     // address of the request on the bus / in flight
    logic            drop_pending; // redirect seen while a request was held in REQ

    logic [XLEN-1:0] buf_pc   [DEPTH];
    logic [XLEN-1:0] buf_inst [DEPTH];
    logic            buf_err  [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count, count_next;

    logic            empty, accept, rsp_take, push, pop, bypass;
    logic [XLEN-1:0] redirect_aligned;
    logic            unused_redirect_lsb;

    assign redirect_aligned    = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsb = ^bus.redirect_pc[1:0];
    assign dbg_state           = state;

    assign empty    = (count == '0);
    assign accept   = (state == REQ) && bus.mem_req_ready;
    assign rsp_take = (state == WAIT) && bus.mem_rsp_valid;

`ifdef YSYX_23060075_IFU_PREFETCH_BYPASS_EN
    assign bypass = empty && rsp_take && !bus.redirect_valid && !rst;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed response that decode accepts is consumed without queueing.
    assign push = rsp_take && !bus.redirect_valid && !(bypass && bus.out_ready);
    assign pop  = !empty && bus.out_ready;

    assign count_next = count + CW'(push) - CW'(pop);

    // Output side
    always_comb begin
        bus.out_valid = !empty;
        bus.out_inst  = buf_inst[rd_ptr];
        bus.out_pc    = buf_pc[rd_ptr];
        bus.out_err   = !empty && buf_err[rd_ptr];
        if (bypass) begin
            bus.out_valid = 1'b1;
            bus.out_inst  = bus.mem_rsp_data;
            bus.out_pc    = req_addr;
            bus.out_err   = bus.mem_rsp_err;
        end
    end

    assign bus.mem_req_valid = (state == REQ);
    assign bus.mem_req_addr  = req_addr;

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!bus.redirect_valid && (count < CW'(DEPTH)))
                    state_next = REQ;
            end
            REQ: begin
                // Address is held through a redirect; its response is
                // discarded once the request finally goes out.
                if (accept)
                    state_next = (bus.redirect_valid || drop_pending) ? DROP : WAIT;
            end
            WAIT: begin
                if (bus.mem_rsp_valid) begin
                    if (bus.redirect_valid)
                        state_next = IDLE;
                    else
                        state_next = (count_next < CW'(DEPTH)) ? REQ : IDLE;
                end else if (bus.redirect_valid) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                // A redirect here only moves fpc; the outstanding response
                // still has to be swallowed, and once it is there is nothing
                // left in flight.
                if (bus.mem_rsp_valid)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            fpc          <= RESET_PC;
            req_addr     <= RESET_PC;
            drop_pending <= 1'b0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
        end else begin
            state <= state_next;

            if ((state != REQ) && (state_next == REQ))
                req_addr <= fpc;

            // A pending redirect already holds the new fpc; the dropped
            // request must not advance it.
            if (bus.redirect_valid)
                fpc <= redirect_aligned;
            else if (accept && !drop_pending)
                fpc <= fpc + XLEN'(4);

            if ((state == REQ) && !accept)
                drop_pending <= drop_pending || bus.redirect_valid;
            else
                drop_pending <= 1'b0;

            if (bus.redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    buf_pc[wr_ptr]   <= req_addr;
                    buf_inst[wr_ptr] <= bus.mem_rsp_data;
                    buf_err[wr_ptr]  <= bus.mem_rsp_err;
                    wr_ptr           <= wr_ptr + PW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= count_next;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_23060075_ifu_prefetch.sv
module tb_ysyx_23060075_ifu_prefetch;
    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
`ifdef YSYX_23060075_IFU_PREFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    ysyx_23060075_ifu_prefetch_if #(.XLEN(XLEN)) bus ();

    ysyx_23060075_ifu_prefetch #(.XLEN(XLEN), .DEPTH(4), .RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // memory knobs
    int          ready_mode = 0;  // 0 always ready, 1 random, 2 never
    int          lat_min    = 1;
    int          lat_max    = 1;
    logic [31:0] err_addr   = 32'h0;

    logic [XLEN-1:0] acc_log[$];     // accepted request addresses
    logic [XLEN-1:0] pop_pc_log[$];  // pcs handed to decode
    logic            pop_err_log[$];
    logic [XLEN-1:0] exp_q[$];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---------------- memory responder ----------------
    logic        acc_flag;
    logic [31:0] acc_addr;
    logic        pend;
    int          pend_cnt;
    logic [31:0] pend_addr;

    initial begin
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        bus.mem_rsp_err   = 1'b0;
        acc_flag = 1'b0;
        pend     = 1'b0;
        pend_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                pend              = 1'b0;
                acc_flag          = 1'b0;
                bus.mem_rsp_valid = 1'b0;
            end else begin
                if (acc_flag) begin
                    pend      = 1'b1;
                    pend_cnt  = $urandom_range(lat_max - 1, lat_min - 1);
                    pend_addr = acc_addr;
                    acc_flag  = 1'b0;
                end
                bus.mem_rsp_valid = 1'b0;
                if (pend) begin
                    if (pend_cnt == 0) begin
                        bus.mem_rsp_valid = 1'b1;
                        bus.mem_rsp_data  = mem_data(pend_addr);
                        bus.mem_rsp_err   = (pend_addr == err_addr);
                        pend              = 1'b0;
                    end else begin
                        pend_cnt--;
                    end
                end
            end
            case (ready_mode)
                0:       bus.mem_req_ready = 1'b1;
                1:       bus.mem_req_ready = 1'($urandom_range(0, 1));
                default: bus.mem_req_ready = 1'b0;
            endcase
            @(negedge clk);
            if (!rst && bus.mem_req_valid && bus.mem_req_ready) begin
                n_checks++;
                if (pend || bus.mem_rsp_valid) begin
                    n_fail++;
                    $display("FAIL one_outstanding: request 0x%08h accepted while a response is pending", bus.mem_req_addr);
                end
                acc_flag = 1'b1;
                acc_addr = bus.mem_req_addr;
                acc_log.push_back(bus.mem_req_addr);
            end
        end
    end

    // ---------------- scoreboard / reference model ----------------
    // Decode must see a strictly sequential stream that restarts at the
    // aligned redirect target; every pop is compared against it.
    logic [31:0] exp_pc;
    logic        prev_hold;
    logic [31:0] prev_addr;

    initial begin
        exp_pc    = RESET_PC;
        prev_hold = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_pc    = RESET_PC;
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    n_checks++;
                    if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== prev_addr) begin
                        n_fail++;
                        $display("FAIL req_stable: valid=%0b addr=0x%08h, required valid=1 addr=0x%08h",
                                 bus.mem_req_valid, bus.mem_req_addr, prev_addr);
                    end
                end
                prev_hold = bus.mem_req_valid && !bus.mem_req_ready;
                prev_addr = bus.mem_req_addr;
                if (bus.out_valid && bus.out_ready) begin
                    n_checks++;
                    if (bus.out_pc !== exp_pc || bus.out_inst !== mem_data(exp_pc) ||
                        bus.out_err !== (exp_pc == err_addr)) begin
                        n_fail++;
                        $display("FAIL out_stream: pc=0x%08h inst=0x%08h err=%0b, required pc=0x%08h inst=0x%08h err=%0b",
                                 bus.out_pc, bus.out_inst, bus.out_err,
                                 exp_pc, mem_data(exp_pc), (exp_pc == err_addr));
                    end
                    pop_pc_log.push_back(bus.out_pc);
                    pop_err_log.push_back(bus.out_err);
                    exp_pc = exp_pc + 32'd4;
                end
                if (bus.redirect_valid)
                    exp_pc = bus.redirect_pc & 32'hffff_fffc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b0;
        ready_mode = 0;
        lat_min    = 1;
        lat_max    = 1;
        err_addr   = 32'h0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        acc_log.delete();
        pop_pc_log.delete();
        pop_err_log.delete();
    endtask

    task automatic wait_log(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (acc_log.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_pops(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (pop_pc_log.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        // redirect and handshakes held active during reset must be ignored
        rst                = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h1234_5678;
        bus.out_ready      = 1'b1;
        ready_mode         = 0;
        repeat (3) tick();
        n_checks++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %0b want 0", bus.mem_req_valid); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
        n_checks++; if (bus.out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err: got %0b want 0", bus.out_err); end
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0 (IDLE)", dbg_state); end
        rst                = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b0;
        tick();
        n_checks++; if (bus.mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL first_req_valid: got %0b want 1", bus.mem_req_valid); end
        n_checks++; if (bus.mem_req_addr !== RESET_PC) begin n_fail++; $display("FAIL first_req_addr: got 0x%08h want 0x%08h", bus.mem_req_addr, RESET_PC); end
    endtask

    task automatic test_sequential();
        bit ok;
        logic [31:0] got;
        do_reset();
        bus.out_ready = 1'b1;
        exp_q = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
        wait_log(3, 100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL seq_timeout: %0d requests seen, want 3", acc_log.size()); end
        for (int i = 0; i < 3; i++) begin
            got = acc_log[i];
            n_checks++;
            if (got !== exp_q[i]) begin n_fail++; $display("FAIL seq_addr%0d: got 0x%08h want 0x%08h", i, got, exp_q[i]); end
        end
        wait_pops(3, 50, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL seq_pops: %0d pops, want 3", pop_pc_log.size()); end
    endtask

    task automatic test_backpressure();
        logic [31:0] got;
        do_reset();
        repeat (30) tick();
        n_checks++; if (acc_log.size() != 4) begin n_fail++; $display("FAIL bp_accepts: got %0d want 4", acc_log.size()); end
        n_checks++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_idle: got %0b want 0", bus.mem_req_valid); end
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== RESET_PC) begin n_fail++; $display("FAIL bp_head: valid=%0b pc=0x%08h want 1 0x%08h", bus.out_valid, bus.out_pc, RESET_PC); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        repeat (20) tick();
        n_checks++; if (acc_log.size() != 5) begin n_fail++; $display("FAIL bp_refill: got %0d accepts want 5", acc_log.size()); end
        got = acc_log[4];
        n_checks++; if (got !== 32'h8000_0010) begin n_fail++; $display("FAIL bp_refill_addr: got 0x%08h want 0x80000010", got); end
        n_checks++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_idle2: got %0b want 0", bus.mem_req_valid); end
    endtask

    task automatic test_redirect_wait();
        bit ok;
        logic [31:0] got;
        do_reset();
        lat_min = 4;
        lat_max = 4;
        wait_log(3, 100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rw_timeout: %0d requests, want 3", acc_log.size()); end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_1003;
        tick();
        bus.redirect_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rw_flush: out_valid=%0b want 0", bus.out_valid); end
        n_checks++; if (dbg_state !== 2'd3) begin n_fail++; $display("FAIL rw_state: got %0d want 3 (DROP)", dbg_state); end
        wait_log(4, 100, ok);
        got = acc_log[3];
        n_checks++; if (!ok || got !== 32'h8000_1000) begin n_fail++; $display("FAIL rw_next_addr: got 0x%08h want 0x80001000", got); end
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) break;
            tick();
        end
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h8000_1000) begin n_fail++; $display("FAIL rw_out_pc: valid=%0b pc=0x%08h want 1 0x80001000", bus.out_valid, bus.out_pc); end
    endtask

    task automatic test_redirect_req();
        bit ok;
        logic [31:0] got;
        do_reset();
        bus.out_ready = 1'b1;
        wait_log(1, 50, ok);
        ready_mode = 2;
        repeat (4) tick();
        n_checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h8000_0004) begin n_fail++; $display("FAIL rr_held: valid=%0b addr=0x%08h want 1 0x80000004", bus.mem_req_valid, bus.mem_req_addr); end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0100;
        tick();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h8000_0004) begin n_fail++; $display("FAIL rr_stable%0d: valid=%0b addr=0x%08h want 1 0x80000004", i, bus.mem_req_valid, bus.mem_req_addr); end
            tick();
        end
        ready_mode = 0;
        wait_log(3, 100, ok);
        got = acc_log[1];
        n_checks++; if (got !== 32'h8000_0004) begin n_fail++; $display("FAIL rr_acc1: got 0x%08h want 0x80000004", got); end
        got = acc_log[2];
        n_checks++; if (!ok || got !== 32'h8000_0100) begin n_fail++; $display("FAIL rr_acc2: got 0x%08h want 0x80000100", got); end
        wait_pops(2, 50, ok);
        got = pop_pc_log[1];
        n_checks++; if (!ok || got !== 32'h8000_0100) begin n_fail++; $display("FAIL rr_out_pc: got 0x%08h want 0x80000100", got); end
    endtask

    task automatic test_fault();
        bit ok;
        logic [31:0] pc;
        logic        er;
        do_reset();
        err_addr      = 32'h8000_0004;
        bus.out_ready = 1'b1;
        wait_pops(3, 100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL flt_timeout: %0d pops want 3", pop_pc_log.size()); end
        pc = pop_pc_log[1];
        er = pop_err_log[1];
        n_checks++; if (pc !== 32'h8000_0004 || er !== 1'b1) begin n_fail++; $display("FAIL flt_entry: pc=0x%08h err=%0b want 0x80000004 1", pc, er); end
        pc = pop_pc_log[2];
        er = pop_err_log[2];
        n_checks++; if (pc !== 32'h8000_0008 || er !== 1'b0) begin n_fail++; $display("FAIL flt_next: pc=0x%08h err=%0b want 0x80000008 0", pc, er); end
    endtask

    task automatic test_bypass_timing();
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.mem_rsp_valid) break;
            tick();
        end
        n_checks++; if (bus.mem_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL byp_rsp_timeout: no response seen"); end
        n_checks++; if (bus.out_valid !== BYP) begin n_fail++; $display("FAIL byp_same_cycle: out_valid=%0b want %0b", bus.out_valid, BYP); end
        tick();
        n_checks++; if (bus.out_valid !== !BYP) begin n_fail++; $display("FAIL byp_next_cycle: out_valid=%0b want %0b", bus.out_valid, !BYP); end
    endtask

    task automatic test_random();
        logic [31:0] r;
        do_reset();
        ready_mode = 1;
        lat_min    = 1;
        lat_max    = 3;
        err_addr   = 32'h8000_0010;
        for (int i = 0; i < 3000; i++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) begin
                r = $urandom;
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = 32'h8000_0000 | (r & 32'h0000_00ff);
            end else begin
                bus.redirect_valid = 1'b0;
            end
            tick();
        end
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b0;
        n_checks++; if (pop_pc_log.size() < 100) begin n_fail++; $display("FAIL rnd_progress: %0d pops want >=100", pop_pc_log.size()); end
    endtask

    initial begin
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_req();
        test_fault();
        test_bypass_timing();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_23060075_ifu_prefetch.md
YSYX_23060075_IFU_PREFETCH -- requirements
Module: ysyx_23060075_ifu_prefetch

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the address, instruction and PC width.
REQ-002 Parameter DEPTH, default 4, SHALL set the instruction buffer entry count (power of two, >=2).
REQ-003 Parameter RESET_PC, default 32'h8000_0000, SHALL be the fetch PC after reset.
REQ-004 clk  in  1  clock; all state SHALL update on posedge clk.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 redirect_valid  in  1  flush buffer and restart fetch at redirect_pc.
REQ-007 redirect_pc  in  XLEN  new fetch address; bits [1:0] SHALL be ignored (treated as 0).
REQ-008 mem_req_valid  out  1  fetch request valid.
REQ-009 mem_req_ready  in  1  memory accepts request.
REQ-010 mem_req_addr  out  XLEN  fetch address, word aligned.
REQ-011 mem_rsp_valid  in  1  response valid; exactly one response per accepted request, never same cycle as acceptance.
REQ-012 mem_rsp_data  in  XLEN  fetched instruction.
REQ-013 mem_rsp_err  in  1  access fault for that fetch.
REQ-014 out_valid  out  1  buffered instruction available.
REQ-015 out_ready  in  1  decode accepts instruction.
REQ-016 out_inst  out  XLEN  instruction; out_pc  out  XLEN  its address; out_err  out  1  its fault flag.

Function
REQ-017 FSM SHALL have states IDLE, REQ, WAIT, DROP; at most one request SHALL be outstanding.
REQ-018 IDLE -> REQ when buffer count < DEPTH; else stay IDLE.
REQ-019 REQ: mem_req_valid=1, mem_req_addr=req_addr register; on mem_req_valid&&mem_req_ready -> WAIT and fpc <= fpc+4 (wraps modulo 2^XLEN).
REQ-020 mem_req_addr SHALL stay stable from assertion until acceptance, including across a redirect.
REQ-021 WAIT: on mem_rsp_valid push {req_addr, mem_rsp_data, mem_rsp_err}; next state REQ if post-push/pop count < DEPTH, else IDLE; req_addr <= fpc on entering REQ.
REQ-022 DROP: discard the next response without pushing, then -> IDLE.
REQ-023 Buffer: FIFO, DEPTH entries, wrap-around pointers; push and pop in same cycle SHALL be legal when non-empty; count unchanged.
REQ-024 out_valid = buffer non-empty; out_* = head entry; pop on out_valid&&out_ready.
REQ-025 redirect_valid SHALL: empty buffer and set fpc <= {redirect_pc[XLEN-1:2],2'b00} at next edge, overriding any same-cycle push; a same-cycle pop is consumed normally.
REQ-026 Redirect in IDLE -> IDLE; in REQ without acceptance -> stay REQ with old address, then -> DROP on acceptance; in REQ with acceptance -> DROP; in WAIT without response -> DROP; in WAIT with response -> IDLE (response discarded); in DROP -> DROP.
REQ-027 After any redirect the first pushed entry SHALL carry out_pc = redirected address.
REQ-028 Faulting fetch (mem_rsp_err=1) SHALL be buffered with out_err=1; fetching SHALL continue sequentially.

Reset
REQ-029 On rst: state IDLE, fpc = req_addr = RESET_PC, buffer empty, mem_req_valid=0, out_valid=0, out_err=0; in-flight response after reset SHALL be ignored by memory contract (memory is reset too).
REQ-030 rst SHALL override redirect_valid and all handshakes in the same cycle.

Configuration
REQ-031 Macro YSYX_23060075_IFU_PREFETCH_BYPASS_EN defined: when buffer empty, state WAIT, mem_rsp_valid=1, no redirect, response SHALL drive out_* combinationally with out_valid=1; if out_ready=1 it SHALL not be pushed.
REQ-032 Macro undefined: out_valid SHALL depend only on buffer state; earliest out_valid is one cycle after mem_rsp_valid.

Verification
REQ-033 Reset, mem_req_ready=1, response 1 cycle after accept, out_ready=1 -> addresses 0x80000000, 0x80000004, 0x80000008 issued in order; out_pc matches.
REQ-034 out_ready=0, DEPTH=4 -> exactly 4 requests accepted, then mem_req_valid=0 until a pop; pop -> one new request.
REQ-035 Redirect to 0x80001003 while WAIT on 0x80000008 -> that response dropped, buffer empty, next request 0x80001000, out_pc=0x80001000.
REQ-036 Redirect while REQ held (mem_req_ready=0) on 0x80000004 -> address stays 0x80000004 until accept, response dropped, then 0x80000100 fetched.
REQ-037 mem_rsp_err=1 on 0x80000004 -> out_err=1 with out_pc=0x80000004; following entry out_pc=0x80000008, out_err=0.
REQ-038 BYPASS_EN, empty buffer, out_ready=1 -> out_valid in same cycle as mem_rsp_valid; without macro -> one cycle later.
